patch_override_ctrl: RTL and testbench
======================================

# patch_override_ctrl

Programmable override controller for a patched module's control port. It observes the original signal values the patched module exports on its control output, and waits for a configured trigger pattern on those signals. On a hit it forces selected signals to configured values for a programmed number of cycles. The forced values go back to the patched module as the "controlled" versions. It sits between the patched module and the SoC patch configuration bus, one instance per patched module.

## Interface
- `N_SIGNALS`, 4, number of patchable signals (1..16)
- `CNT_W`, 8, duration counter width (1..16)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cfg_valid` in 1: config write request
- `cfg_ready` out 1: config write accepted when `cfg_valid && cfg_ready`
- `cfg_addr` in 3: register address
- `cfg_wdata` in 16: write data, LSB-aligned
- `control_port_in` in N_SIGNALS: original signal values from the patched module
- `control_port_out` out N_SIGNALS: controlled values returned to the patched module
- `patch_armed` out 1: FSM in ARMED
- `patch_active` out 1: FSM in ACTIVE, override applied

## Operation
- Registers, all reset to 0; writes take `cfg_wdata` LSBs:
  - 0 TRIG_MASK[N-1:0]
  - 1 TRIG_VALUE[N-1:0]
  - 2 OVR_EN[N-1:0]
  - 3 OVR_VAL[N-1:0]
  - 4 DURATION[CNT_W-1:0]
  - 5 CTRL: write-only pulses; bit0 ARM, bit1 DISARM
  - Addresses 6–7 are accepted and ignored.
- Data path is combinational, zero latency: `control_port_out[i] = (patch_active && OVR_EN[i]) ? OVR_VAL[i] : control_port_in[i]`.
- Trigger hit: `((control_port_in ^ TRIG_VALUE) & TRIG_MASK) == 0`. A zero mask always hits.
- FSM states are IDLE, ARMED and ACTIVE. Transitions:
  - IDLE → ARMED on an accepted CTRL write with ARM=1 and DISARM=0.
  - ARMED → ACTIVE on a trigger hit; the counter loads DURATION.
  - ACTIVE with DURATION≠0: the counter decrements each cycle, and the FSM goes ACTIVE → IDLE in the cycle the counter equals 1.
  - ACTIVE with DURATION=0: sticky, held until disarmed.
  - Any state → IDLE on an accepted CTRL write with DISARM=1.
- Priority:
  - DISARM beats ARM in the same write.
  - DISARM beats a trigger hit in the same cycle.
  - ARM written while ARMED or ACTIVE is ignored.
- The trigger is not evaluated in IDLE or ACTIVE. There is no re-arm after expiry; software re-arms.
- `cfg_ready = rst_n && !(state==ACTIVE && cfg_addr!=5)`. Writes to addresses 0–4 stall during ACTIVE, so the override is stable for its whole window. CTRL is always accepted.

## Timing
- Reset values:
  - `cfg_ready=0`, `patch_armed=0`, `patch_active=0`
  - `control_port_out = control_port_in` (pass-through)
  - all registers 0; state IDLE
- Reset asserted mid-ACTIVE: override drops immediately (asynchronous) and the counter clears.
- A config write accepted at edge t is visible in registers from cycle t+1.
- ARM accepted at edge t: ARMED from t+1, and the trigger is first sampled at edge t+1.
- Trigger hit sampled at edge t: ACTIVE, and override applied, from t+1 for exactly DURATION cycles. IDLE from t+1+DURATION.
- `cfg_ready` depends combinationally on state and `cfg_addr`. No combinational path from `cfg_valid` to `cfg_ready`.
- No combinational path from `control_port_in` to any FSM output; only to `control_port_out`.

## Structure
- Package `patch_pkg` holds:
  - state enum `patch_state_t` {IDLE, ARMED, ACTIVE}
  - address constants `PATCH_ADDR_TRIG_MASK` … `PATCH_ADDR_CTRL`
  - CTRL bit indices `PATCH_CTRL_ARM`, `PATCH_CTRL_DISARM`
- Sub-module `patch_cfg_regs`: register file, address decode, `cfg_ready` generation and CTRL pulse outputs.
- The top level holds the FSM, duration counter, trigger compare and output mux.

## Test plan
All scenarios use N=4, CNT_W=8.
- Reset/pass-through: hold `rst_n=0`, drive `control_port_in` 4'hA → `control_port_out`=4'hA, `cfg_ready`=0, `patch_armed`=0, `patch_active`=0.
- Timed override:
  - Setup: MASK=4'h3, VALUE=4'h1, OVR_EN=4'h8, OVR_VAL=4'h0, DURATION=3, then ARM.
  - Stimulus: drive `control_port_in`=4'h9.
  - Response: `control_port_out`=4'h1 for exactly 3 cycles starting the cycle after the hit, then 4'h9 with the FSM in IDLE.
- Sticky and disarm:
  - Setup: DURATION=0, MASK=0, ARM; drive input 4'h5.
  - Response: ACTIVE indefinitely.
  - Then write CTRL=2'b10 → IDLE next cycle and output back to the input value.
- Stall during ACTIVE:
  - Stimulus: while ACTIVE, request a write to addr 3.
  - Response: `cfg_ready`=0 until expiry, then the write is accepted; OVR_VAL stays unchanged throughout the window.
- Simultaneous events:
  - ARMED with trigger hit and CTRL=2'b11 write in the same cycle → next state IDLE, `patch_active` never asserts.
  - Separately, write ARM while ACTIVE → ignored, DURATION window unchanged.
- Async reset mid-ACTIVE: deassert `rst_n` mid-cycle → `control_port_out` returns to `control_port_in` before the next edge; after release, all registers read as 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/patch_pkg.sv
// Shared types and constants for the patch override controller:
// FSM state encoding, config register map and CTRL bit positions.
package patch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } patch_state_t;

    localparam logic [2:0] PATCH_ADDR_TRIG_MASK  = 3'd0;
    localparam logic [2:0] PATCH_ADDR_TRIG_VALUE = 3'd1;
    localparam logic [2:0] PATCH_ADDR_OVR_EN     = 3'd2;
    localparam logic [2:0] PATCH_ADDR_OVR_VAL    = 3'd3;
    localparam logic [2:0] PATCH_ADDR_DURATION   = 3'd4;
    localparam logic [2:0] PATCH_ADDR_CTRL       = 3'd5;

    localparam int PATCH_CTRL_ARM    = 0;
    localparam int PATCH_CTRL_DISARM = 1;

endpackage

// File: rtl/patch_cfg_regs.sv
// Config register file for the patch override controller: address decode,
// write acceptance (stalls non-CTRL writes while the override is active) and CTRL pulses.
module patch_cfg_regs
    import patch_pkg::*;
#(
    parameter int N_SIGNALS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [2:0]           cfg_addr_i,
    input  logic [15:0]          cfg_wdata_i,
    input  logic                 active_i,
    output logic [N_SIGNALS-1:0] trig_mask_o,
    output logic [N_SIGNALS-1:0] trig_value_o,
    output logic [N_SIGNALS-1:0] ovr_en_o,
    output logic [N_SIGNALS-1:0] ovr_val_o,
    output logic [CNT_W-1:0]     duration_o,
    output logic                 arm_pulse_o,
    output logic                 disarm_pulse_o
);

    logic [N_SIGNALS-1:0] trig_mask_q, trig_mask_d;
    logic [N_SIGNALS-1:0] trig_value_q, trig_value_d;
    logic [N_SIGNALS-1:0] ovr_en_q, ovr_en_d;
    logic [N_SIGNALS-1:0] ovr_val_q, ovr_val_d;
    logic [CNT_W-1:0]     duration_q, duration_d;
    logic                 accept;
    logic                 unused_wdata;

    // Handshake: a write is accepted on a rising edge where cfg_valid_i && cfg_ready_o.
    // Ready never depends on valid; CTRL stays writable so software can always disarm.
    assign cfg_ready_o  = rst_n && !(active_i && (cfg_addr_i != PATCH_ADDR_CTRL));
    assign accept       = cfg_valid_i && cfg_ready_o;
    assign unused_wdata = ^cfg_wdata_i;

    assign arm_pulse_o    = accept && (cfg_addr_i == PATCH_ADDR_CTRL) && cfg_wdata_i[PATCH_CTRL_ARM];
    assign disarm_pulse_o = accept && (cfg_addr_i == PATCH_ADDR_CTRL) && cfg_wdata_i[PATCH_CTRL_DISARM];

    always_comb begin
        trig_mask_d  = trig_mask_q;
        trig_value_d = trig_value_q;
        ovr_en_d     = ovr_en_q;
        ovr_val_d    = ovr_val_q;
        duration_d   = duration_q;
        if (accept) begin
            case (cfg_addr_i)
                PATCH_ADDR_TRIG_MASK:  trig_mask_d  = cfg_wdata_i[N_SIGNALS-1:0];
                PATCH_ADDR_TRIG_VALUE: trig_value_d = cfg_wdata_i[N_SIGNALS-1:0];
                PATCH_ADDR_OVR_EN:     ovr_en_d     = cfg_wdata_i[N_SIGNALS-1:0];
                PATCH_ADDR_OVR_VAL:    ovr_val_d    = cfg_wdata_i[N_SIGNALS-1:0];
                PATCH_ADDR_DURATION:   duration_d   = cfg_wdata_i[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_mask_q  <= '0;
            trig_value_q <= '0;
            ovr_en_q     <= '0;
            ovr_val_q    <= '0;
            duration_q   <= '0;
        end else begin
            trig_mask_q  <= trig_mask_d;
            trig_value_q <= trig_value_d;
            ovr_en_q     <= ovr_en_d;
            ovr_val_q    <= ovr_val_d;
            duration_q   <= duration_d;
        end
    end

    assign trig_mask_o  = trig_mask_q;
    assign trig_value_o = trig_value_q;
    assign ovr_en_o     = ovr_en_q;
    assign ovr_val_o    = ovr_val_q;
    assign duration_o   = duration_q;

endmodule

// File: rtl/patch_override_ctrl.sv
// Override controller for one patched module: waits (when armed) for a trigger pattern
// on the exported control signals, then forces selected signals for a programmed window.
module patch_override_ctrl
    import patch_pkg::*;
#(
    parameter int N_SIGNALS = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [2:0]           cfg_addr,
    input  logic [15:0]          cfg_wdata,
    input  logic [N_SIGNALS-1:0] control_port_in,
    output logic [N_SIGNALS-1:0] control_port_out,
    output logic                 patch_armed,
    output logic                 patch_active
);

    patch_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_SIGNALS-1:0] trig_mask, trig_value, ovr_en, ovr_val;
    logic [CNT_W-1:0]     duration;
    logic                 arm_pulse, disarm_pulse;
    logic                 hit;

    patch_cfg_regs #(
        .N_SIGNALS (N_SIGNALS),
        .CNT_W     (CNT_W)
    ) u_cfg_regs (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_addr_i     (cfg_addr),
        .cfg_wdata_i    (cfg_wdata),
        .active_i       (state_q == ACTIVE),
        .trig_mask_o    (trig_mask),
        .trig_value_o   (trig_value),
        .ovr_en_o       (ovr_en),
        .ovr_val_o      (ovr_val),
        .duration_o     (duration),
        .arm_pulse_o    (arm_pulse),
        .disarm_pulse_o (disarm_pulse)
    );

    assign hit = (((control_port_in ^ trig_value) & trig_mask) == '0);

    // A loaded count of zero means the override is sticky until software disarms it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arm_pulse && !disarm_pulse) state_d = ARMED;
            end
            ARMED: begin
                if (disarm_pulse) begin
                    state_d = IDLE;
                end else if (hit) begin
                    state_d = ACTIVE;
                    cnt_d   = duration;
                end
            end
            ACTIVE: begin
                if (disarm_pulse || (cnt_q == CNT_W'(1))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign patch_armed      = (state_q == ARMED);
    assign patch_active     = (state_q == ACTIVE);
    assign control_port_out = (ovr_en & {N_SIGNALS{patch_active}} & ovr_val)
                            | (~(ovr_en & {N_SIGNALS{patch_active}}) & control_port_in);

endmodule

// File: tb/tb_patch_override_ctrl.sv
// Directed bench for patch_override_ctrl (N_SIGNALS=4, CNT_W=8): pass-through, timed and
// sticky overrides, write stalls, same-cycle priorities and asynchronous reset.
module tb_patch_override_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [3:0]  control_port_in;
    logic [3:0]  control_port_out;
    logic        patch_armed;
    logic        patch_active;

    int n_assert = 0;
    int n_fail   = 0;

    patch_override_ctrl #(
        .N_SIGNALS (4),
        .CNT_W     (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .control_port_in  (control_port_in),
        .control_port_out (control_port_out),
        .patch_armed      (patch_armed),
        .patch_active     (patch_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the rising edge on which the write was accepted.
    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        while (!cfg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wr_timeout", 16'(n < 100), 16'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        cfg_valid       = 1'b0;
        cfg_addr        = 3'd0;
        cfg_wdata       = 16'd0;
        control_port_in = 4'hA;

        // Reset and pass-through
        #2;
        chk("rst_out", 16'(control_port_out), 16'hA);
        chk("rst_ready", 16'(cfg_ready), 16'd0);
        chk("rst_armed", 16'(patch_armed), 16'd0);
        chk("rst_active", 16'(patch_active), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 16'(cfg_ready), 16'd1);

        // Timed override: mask 3, value 1, force bit3 to 0 for 3 cycles
        cfg_write(3'd0, 16'h3);
        cfg_write(3'd1, 16'h1);
        cfg_write(3'd2, 16'h8);
        cfg_write(3'd3, 16'h0);
        cfg_write(3'd4, 16'd3);
        control_port_in = 4'h2;
        cfg_write(3'd5, 16'h1);
        chk("t_armed", 16'(patch_armed), 16'd1);
        chk("t_not_active", 16'(patch_active), 16'd0);
        control_port_in = 4'h9;
        #1;
        chk("t_pre_hit_out", 16'(control_port_out), 16'h9);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t_active", 16'(patch_active), 16'd1);
            chk("t_forced_out", 16'(control_port_out), 16'h1);
        end
        tick();
        chk("t_expired", 16'(patch_active), 16'd0);
        chk("t_idle_armed", 16'(patch_armed), 16'd0);
        chk("t_pass_out", 16'(control_port_out), 16'h9);
        tick();
        chk("t_no_rearm", 16'({patch_armed, patch_active}), 16'd0);

        // Stall of OVR_VAL write during an active window
        control_port_in = 4'h2;
        cfg_write(3'd5, 16'h1);
        control_port_in = 4'h9;
        tick();
        chk("s_active", 16'(patch_active), 16'd1);
        cfg_valid = 1'b1;
        cfg_addr  = 3'd3;
        cfg_wdata = 16'hF;
        #1;
        chk("s_stall0", 16'(cfg_ready), 16'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("s_stall", 16'(cfg_ready), 16'd0);
            chk("s_window_active", 16'(patch_active), 16'd1);
            chk("s_ovr_stable", 16'(control_port_out), 16'h1);
        end
        tick();
        chk("s_expired", 16'(patch_active), 16'd0);
        chk("s_ready", 16'(cfg_ready), 16'd1);
        tick();
        cfg_valid = 1'b0;

        // ARM while ACTIVE is ignored; new OVR_VAL=F forces bit3 high
        control_port_in = 4'h2;
        cfg_write(3'd5, 16'h1);
        control_port_in = 4'h1;
        tick();
        chk("a_active", 16'(patch_active), 16'd1);
        chk("a_new_ovr_val", 16'(control_port_out), 16'h9);
        cfg_write(3'd5, 16'h1);
        chk("a_still_active", 16'(patch_active), 16'd1);
        tick();
        chk("a_last_cycle", 16'(patch_active), 16'd1);
        tick();
        chk("a_expired_on_time", 16'({patch_armed, patch_active}), 16'd0);

        // Sticky override with DURATION=0 and MASK=0, then disarm
        cfg_write(3'd4, 16'd0);
        cfg_write(3'd0, 16'h0);
        control_port_in = 4'h5;
        cfg_write(3'd5, 16'h1);
        chk("k_armed", 16'(patch_armed), 16'd1);
        tick();
        chk("k_active", 16'(patch_active), 16'd1);
        chk("k_out", 16'(control_port_out), 16'hD);
        repeat (20) @(posedge clk);
        #1;
        chk("k_still_active", 16'(patch_active), 16'd1);
        cfg_addr = 3'd5;
        #1;
        chk("k_ctrl_ready", 16'(cfg_ready), 16'd1);
        cfg_addr = 3'd0;
        #1;
        chk("k_reg_stall", 16'(cfg_ready), 16'd0);
        cfg_write(3'd5, 16'h2);
        chk("k_disarmed", 16'({patch_armed, patch_active}), 16'd0);
        chk("k_pass_out", 16'(control_port_out), 16'h5);

        // DISARM beats ARM from IDLE
        cfg_write(3'd5, 16'h3);
        chk("p_arm_disarm_idle", 16'(patch_armed), 16'd0);

        // ARMED with a hit and CTRL=3 in the same cycle
        cfg_write(3'd0, 16'h3);
        control_port_in = 4'h2;
        cfg_write(3'd5, 16'h1);
        chk("p_armed", 16'(patch_armed), 16'd1);
        @(negedge clk);
        control_port_in = 4'h9;
        cfg_valid = 1'b1;
        cfg_addr  = 3'd5;
        cfg_wdata = 16'h3;
        #1;
        chk("p_ready", 16'(cfg_ready), 16'd1);
        tick();
        cfg_valid = 1'b0;
        chk("p_disarm_wins", 16'({patch_armed, patch_active}), 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("p_never_active", 16'(patch_active), 16'd0);
        end

        // Asynchronous reset in the middle of a sticky override
        control_port_in = 4'h2;
        cfg_write(3'd5, 16'h1);
        control_port_in = 4'h1;
        tick();
        chk("r_active", 16'(patch_active), 16'd1);
        chk("r_forced", 16'(control_port_out), 16'h9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_out_pass", 16'(control_port_out), 16'h1);
        chk("r_active_drop", 16'(patch_active), 16'd0);
        chk("r_ready_low", 16'(cfg_ready), 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Cleared registers: zero mask hits, no forcing, zero duration is sticky
        cfg_write(3'd5, 16'h1);
        chk("r_armed", 16'(patch_armed), 16'd1);
        chk("r_not_active", 16'(patch_active), 16'd0);
        tick();
        chk("r_zero_mask_hit", 16'(patch_active), 16'd1);
        chk("r_zero_ovr_en", 16'(control_port_out), 16'h1);
        repeat (5) @(posedge clk);
        #1;
        chk("r_zero_duration_sticky", 16'(patch_active), 16'd1);
        cfg_write(3'd5, 16'h2);
        chk("r_disarm", 16'({patch_armed, patch_active}), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
